// File: rtl/matmul_ctrl_seq_pkg.sv
// matmul_ctrl_pkg: 3-bit state encoding and a width helper that never returns 0
package matmul_ctrl_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CALC = 3'd2, S_NEXT = 3'd3, S_DONE = 3'd4;
  typedef enum logic [2:0] {IDLE = S_IDLE, LOAD = S_LOAD, CALC = S_CALC, NEXT = S_NEXT, DONE = S_DONE} state_t;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/matmul_ctrl_seq_if.sv
// matmul_ctrl_seq_if: start/load/abort requests in, phase enables, indices, col_done/finish/busy out
interface matmul_ctrl_seq_if #(parameter int COL_W = 2, parameter int MAC_W = 3);
  logic start_in, xload_done, abort_in, input_load_en, ALU_en, col_done, finish, busy;
  logic [COL_W-1:0] n_cols_in, col_idx;
  logic [MAC_W-1:0] mac_idx;
  modport master(output start_in, n_cols_in, xload_done, abort_in,
                 input input_load_en, ALU_en, mac_idx, col_idx, col_done, finish, busy);
  modport slave(input start_in, n_cols_in, xload_done, abort_in,
                output input_load_en, ALU_en, mac_idx, col_idx, col_done, finish, busy);
endinterface

// File: rtl/matmul_ctrl_seq_wrap_counter.sv
// wrap_counter: clr/en counter wrapping to 0 after MAX; at_max flags cnt == MAX
module wrap_counter #(
  parameter int WIDTH = 3,
  parameter int MAX = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);
  assign at_max = cnt == WIDTH'(MAX);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= at_max ? '0 : cnt + WIDTH'(1);
endmodule

// File: rtl/matmul_ctrl_seq.sv
// matmul_ctrl_seq: load-then-column MAC sequencer; ports clk, rst, bus (start/n_cols/xload/abort in; enables, indices, col_done, finish, busy out)
module matmul_ctrl_seq import matmul_ctrl_pkg::*; #(
  parameter int MAX_COLS = 4,
  parameter int MAC_LEN = 8,
  parameter int COL_W = width_of(MAX_COLS),
  parameter int MAC_W = width_of(MAC_LEN)
) (
  input logic clk,
  input logic rst,
  matmul_ctrl_seq_if.slave bus
);
  state_t state;
  logic [COL_W-1:0] n_q, col_idx;
  logic [MAC_W-1:0] mac_idx;
  logic mac_last, col_max, last_col, clr;
  assign clr = bus.abort_in || !(state inside {LOAD, CALC, NEXT});
  assign last_col = col_max || col_idx == n_q;
  wrap_counter #(.WIDTH(MAC_W), .MAX(MAC_LEN-1)) u_mac (
    .clk, .rst, .clr, .en(state == CALC), .cnt(mac_idx), .at_max(mac_last));
  wrap_counter #(.WIDTH(COL_W), .MAX(MAX_COLS-1)) u_col (
    .clk, .rst, .clr, .en(state == NEXT && !last_col), .cnt(col_idx), .at_max(col_max));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      n_q <= '0;
    end else if (bus.abort_in) state <= IDLE;
    else
      case (state)
        IDLE: if (bus.start_in) begin
          state <= LOAD;
          n_q <= bus.n_cols_in > COL_W'(MAX_COLS-1) ? COL_W'(MAX_COLS-1) : bus.n_cols_in;
        end
        LOAD: state <= bus.xload_done ? CALC : LOAD;
        CALC: state <= mac_last ? NEXT : CALC;
        NEXT: state <= last_col ? DONE : CALC;
        default: state <= IDLE;
      endcase
  assign bus.input_load_en = state == LOAD;
  assign bus.ALU_en = state == CALC;
  assign bus.col_done = state == NEXT;
  assign bus.finish = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.mac_idx = mac_idx;
  assign bus.col_idx = col_idx;
endmodule
